uart_fifo_core: RTL
===================

UART_FIFO_CORE -- requirements
Module: uart_fifo_core

Interface
REQ-001 SHALL have parameter CLK_DIV, default 27, clk cycles per 16x-oversample tick (legal 2..65535).
REQ-002 SHALL have parameter DATA_BITS, default 8, bits per frame (legal 5..8).
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, TX stop bits (legal 1 or 2); RX checks the first stop bit only.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, entries per TX and RX FIFO (power of 2, 2..1024).
REQ-006 SHALL have port clk  in  1  sole clock; all logic is on the rising edge.
REQ-007 SHALL have port Rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have port rx  in  1  asynchronous serial input, idle high.
REQ-009 SHALL have port tx  out  1  serial output, idle high.
REQ-010 SHALL have port tx_wen  in  1  push tx_din into the TX FIFO.
REQ-011 SHALL have port tx_din  in  8  byte to send; bits above DATA_BITS-1 are ignored.
REQ-012 SHALL have port tx_full  out  1  TX FIFO holds FIFO_DEPTH entries.
REQ-013 SHALL have port tx_busy  out  1  TX FIFO non-empty or a frame is in flight.
REQ-014 SHALL have port rx_ren  in  1  pop the RX FIFO head.
REQ-015 SHALL have port rx_dout  out  8  RX FIFO head (first-word fall-through), zero-extended.
REQ-016 SHALL have port rx_data_present  out  1  RX FIFO non-empty.
REQ-017 SHALL have port rx_full  out  1  RX FIFO holds FIFO_DEPTH entries.
REQ-018 SHALL have port err_clr  in  1  clears all sticky error flags.
REQ-019 SHALL have port rx_overrun, rx_frame_err, rx_parity_err  out  1 each  sticky error flags.

Function
REQ-020 Baud counter SHALL count 0..CLK_DIV-1, assert a one-cycle tick at CLK_DIV-1, then wrap to 0; free-running except under reset.
REQ-021 Each serial bit SHALL last exactly 16 ticks; frame order is start(0), data LSB first, optional parity, stop(1).
REQ-022 Parity bit SHALL be the XOR of the DATA_BITS data bits for even mode, and its inverse for odd mode.
REQ-023 TX FSM states SHALL be IDLE, START, DATA, PAR, STOP; PAR is skipped when PARITY=0; STOP lasts 16*STOP_BITS ticks.
REQ-024 In IDLE with the TX FIFO non-empty, TX SHALL pop the head and enter START on the next tick; back-to-back frames SHALL have no idle gap.
REQ-025 tx_wen while tx_full SHALL be ignored, with no change to FIFO contents.
REQ-026 rx SHALL pass through a 2-flop synchroniser before any use.
REQ-027 RX FSM states SHALL be IDLE, START, DATA, PAR, STOP.
REQ-028 RX SHALL leave IDLE on a synchronised high-to-low transition and SHALL re-sample in START at tick count 8.
REQ-029 If the START re-sample is high, RX SHALL return to IDLE (glitch reject) with no flag and no push.
REQ-030 RX SHALL sample the data, parity and stop bits at the 16th tick after the previous sample point.
REQ-031 A parity mismatch SHALL set rx_parity_err; a stop bit sampled low SHALL set rx_frame_err.
REQ-032 On a framing error, RX SHALL wait in STOP until rx is high before returning to IDLE.
REQ-033 The byte SHALL be pushed at the stop sample even when an error is flagged.
REQ-034 A push while rx_full SHALL drop the new byte, set rx_overrun, and leave FIFO contents unchanged.
REQ-035 rx_ren while the RX FIFO is empty SHALL be ignored.
REQ-036 A simultaneous push and pop SHALL keep the count unchanged, including on a full FIFO.
REQ-037 A simultaneous push and pop on an empty FIFO SHALL behave as a push only.
REQ-038 Status outputs (full, present, busy) SHALL be registered and SHALL reflect a push or pop on the following cycle.
REQ-039 Error-flag set SHALL take priority over err_clr in the same cycle.
REQ-040 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full is detected by MSB-differ and low-bits-equal.

Reset
REQ-041 On Rst=1 at a clk edge: tx=1, tx_busy=0, tx_full=0, rx_data_present=0, rx_full=0, rx_dout=0, all error flags 0.
REQ-042 On Rst=1 at a clk edge: both FSMs go to IDLE, both FIFOs empty, baud counter 0.
REQ-043 Reset asserted mid-frame SHALL abort the frame, discard the partial byte and drive tx high on the next cycle.

Verification (CLK_DIV=4, so 1 bit = 64 clk)
REQ-044 8N1: push 0xA5 -> tx low 64 clk, then 1,0,1,0,0,1,0,1, then high 64 clk; tx_busy falls after the stop bit.
REQ-045 Loopback 8E1: tx tied to rx, push 0x00..0x0F -> RX FIFO returns 0x00..0x0F in order, no error flags.
REQ-046 Overrun: FIFO_DEPTH=4, 5 frames received with no reads -> rx_full=1, rx_overrun=1, head still holds the first byte.
REQ-047 Errors: stop bit driven 0 -> rx_frame_err=1 with the byte pushed; wrong parity in 8O1 -> rx_parity_err=1; err_clr -> both 0.
REQ-048 Glitch: rx low for 20 clk -> no push, no flags, RX back in IDLE.
REQ-049 Rst pulse at bit 3 of a TX frame -> tx=1 next cycle, tx_busy=0, FIFO empty; a subsequent push of 0x55 transmits correctly.

Source files
------------

// File: rtl/uart_fifo_core.sv
// rtl/uart_fifo_core.sv - UART transmitter/receiver with TX and RX FIFOs
// Shared 16x baud tick; both FIFOs are first-word fall-through with registered status.
module uart_fifo_core_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         wen_i,
  input  logic [W-1:0] din_i,
  input  logic         ren_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         empty_nxt_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W-1:0] dout_q, dout_d;
  logic         empty_q, full_q, push, pop;

  // A pop frees a slot, so a push into a full FIFO is still taken in the same cycle.
  assign pop  = ren_i && !empty_q;
  assign push = wen_i && (!full_q || pop);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    if (wr_ptr_d == rd_ptr_d) begin
      dout_d = '0;
    end else if (push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
      dout_d = din_i;
    end else begin
      dout_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      empty_q  <= (wr_ptr_d == rd_ptr_d);
      full_q   <= (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

  assign dout_o      = dout_q;
  assign empty_o     = empty_q;
  assign empty_nxt_o = (wr_ptr_d == rd_ptr_d);
  assign full_o      = full_q;
endmodule

module uart_fifo_core #(
  parameter int CLK_DIV    = 27,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       rx,
  output logic       tx,
  input  logic       tx_wen,
  input  logic [7:0] tx_din,
  output logic       tx_full,
  output logic       tx_busy,
  input  logic       rx_ren,
  output logic [7:0] rx_dout,
  output logic       rx_data_present,
  output logic       rx_full,
  input  logic       err_clr,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       rx_parity_err
);
  localparam int          DB        = DATA_BITS;
  localparam logic [4:0]  STOP_LAST = 5'(16 * STOP_BITS - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(DB - 1);
  localparam logic        ODD       = (PARITY == 2);
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  logic [15:0] baud_q;
  logic        tick;

  assign tick = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (Rst) begin
      baud_q <= '0;
    end else begin
      baud_q <= tick ? '0 : baud_q + 16'd1;
    end
  end

  logic [DB-1:0] txf_dout;
  logic          txf_empty, txf_empty_nxt, txf_full;
  logic          tx_pop;

  uart_fifo_core_fifo #(.W(DB), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i       (clk),
    .rst_i       (Rst),
    .wen_i       (tx_wen),
    .din_i       (tx_din[DB-1:0]),
    .ren_i       (tx_pop),
    .dout_o      (txf_dout),
    .empty_o     (txf_empty),
    .empty_nxt_o (txf_empty_nxt),
    .full_o      (txf_full)
  );

  state_t        tx_state_q;
  logic [4:0]    tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [DB-1:0] tx_sh_q;
  logic          tx_par_q, tx_q, tx_busy_q;
  logic          tx_frame_end, tx_active_d;

  // Popping at the last stop tick lets the next start bit follow with no idle gap.
  assign tx_frame_end = (tx_state_q == S_STOP) && tick && (tx_cnt_q == STOP_LAST);
  assign tx_pop       = tick && !txf_empty && ((tx_state_q == S_IDLE) || tx_frame_end);
  assign tx_active_d  = tx_pop || ((tx_state_q != S_IDLE) && !tx_frame_end);

  always_ff @(posedge clk) begin
    if (Rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else if (tx_pop) begin
      tx_state_q <= S_START;
      tx_cnt_q   <= '0;
      tx_sh_q    <= txf_dout;
      tx_par_q   <= (^txf_dout) ^ ODD;
      tx_q       <= 1'b0;
    end else if (tick && (tx_state_q != S_IDLE)) begin
      tx_cnt_q <= tx_cnt_q + 5'd1;
      if (tx_state_q == S_STOP) begin
        if (tx_frame_end) begin
          tx_state_q <= S_IDLE;
        end
      end else if (tx_cnt_q == 5'd15) begin
        tx_cnt_q <= '0;
        case (tx_state_q)
          S_START: begin
            tx_state_q <= S_DATA;
            tx_bit_q   <= '0;
            tx_q       <= tx_sh_q[0];
          end
          S_DATA: begin
            if (tx_bit_q == BIT_LAST) begin
              if (PARITY != 0) begin
                tx_state_q <= S_PAR;
                tx_q       <= tx_par_q;
              end else begin
                tx_state_q <= S_STOP;
                tx_q       <= 1'b1;
              end
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              tx_sh_q  <= tx_sh_q >> 1;
              tx_q     <= tx_sh_q[1];
            end
          end
          S_PAR: begin
            tx_state_q <= S_STOP;
            tx_q       <= 1'b1;
          end
          default: tx_state_q <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      tx_busy_q <= 1'b0;
    end else begin
      tx_busy_q <= tx_active_d || !txf_empty_nxt;
    end
  end

  logic rx_s1_q, rx_s2_q, rx_prev_q;

  always_ff @(posedge clk) begin
    if (Rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  state_t        rx_state_q;
  logic [3:0]    rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [DB-1:0] rx_sh_q;
  logic          rx_perr_q, rx_wait_q, rx_push_q, rx_perr_set_q, rx_ferr_set_q;
  logic          rx_sample;

  assign rx_sample = tick && (rx_cnt_q == 4'd15);

  always_ff @(posedge clk) begin
    if (Rst) begin
      rx_state_q    <= S_IDLE;
      rx_cnt_q      <= '0;
      rx_bit_q      <= '0;
      rx_sh_q       <= '0;
      rx_perr_q     <= 1'b0;
      rx_wait_q     <= 1'b0;
      rx_push_q     <= 1'b0;
      rx_perr_set_q <= 1'b0;
      rx_ferr_set_q <= 1'b0;
    end else begin
      rx_push_q     <= 1'b0;
      rx_perr_set_q <= 1'b0;
      rx_ferr_set_q <= 1'b0;
      if (tick && (rx_state_q != S_IDLE)) begin
        rx_cnt_q <= rx_cnt_q + 4'd1;
      end
      case (rx_state_q)
        S_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_state_q <= S_START;
            rx_cnt_q   <= '0;
            rx_perr_q  <= 1'b0;
            rx_wait_q  <= 1'b0;
          end
        end
        S_START: begin
          if (tick && (rx_cnt_q == 4'd7)) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (rx_sample) begin
            rx_sh_q  <= {rx_s2_q, rx_sh_q[DB-1:1]};
            rx_bit_q <= rx_bit_q + 3'd1;
            if (rx_bit_q == BIT_LAST) begin
              rx_state_q <= (PARITY != 0) ? S_PAR : S_STOP;
            end
          end
        end
        S_PAR: begin
          if (rx_sample) begin
            rx_perr_q  <= rx_s2_q != ((^rx_sh_q) ^ ODD);
            rx_state_q <= S_STOP;
          end
        end
        S_STOP: begin
          // After a low stop bit, hold here until the line returns high.
          if (rx_wait_q) begin
            if (rx_s2_q) begin
              rx_state_q <= S_IDLE;
            end
          end else if (rx_sample) begin
            rx_push_q     <= 1'b1;
            rx_perr_set_q <= rx_perr_q;
            rx_ferr_set_q <= !rx_s2_q;
            rx_wait_q     <= !rx_s2_q;
            if (rx_s2_q) begin
              rx_state_q <= S_IDLE;
            end
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  logic [DB-1:0] rxf_dout;
  logic          rxf_empty, rxf_full, rxf_empty_nxt_unused;
  logic          ovr_q, ferr_q, perr_q, ovr_set;

  uart_fifo_core_fifo #(.W(DB), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i       (clk),
    .rst_i       (Rst),
    .wen_i       (rx_push_q),
    .din_i       (rx_sh_q),
    .ren_i       (rx_ren),
    .dout_o      (rxf_dout),
    .empty_o     (rxf_empty),
    .empty_nxt_o (rxf_empty_nxt_unused),
    .full_o      (rxf_full)
  );

  assign ovr_set = rx_push_q && rxf_full && !(rx_ren && !rxf_empty);

  always_ff @(posedge clk) begin
    if (Rst) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      if (ovr_set)            ovr_q  <= 1'b1;
      else if (err_clr)       ovr_q  <= 1'b0;
      if (rx_ferr_set_q)      ferr_q <= 1'b1;
      else if (err_clr)       ferr_q <= 1'b0;
      if (rx_perr_set_q)      perr_q <= 1'b1;
      else if (err_clr)       perr_q <= 1'b0;
    end
  end

  assign tx              = tx_q;
  assign tx_busy         = tx_busy_q;
  assign tx_full         = txf_full;
  assign rx_dout         = 8'(rxf_dout);
  assign rx_data_present = !rxf_empty;
  assign rx_full         = rxf_full;
  assign rx_overrun      = ovr_q;
  assign rx_frame_err    = ferr_q;
  assign rx_parity_err   = perr_q;
endmodule
